// File: rtl/rca_pkg.sv
// Shared types and constants for the sliced ripple-carry adder controller.
package rca_pkg;

  // Width of the shared adder datapath.
  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slices needed to cover an operand of the given width.
  function automatic int unsigned nslice(input int unsigned width);
    return width / SLICE_W;
  endfunction

endpackage

// File: rtl/rca_multiword_seq_rca4.sv
// 4-bit ripple-carry adder used as the shared slice datapath.
module rca_multiword_seq_rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [4:0] c;

  // Bitwise full-adder chain, carry rippling from bit 0 upward.
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < 4; i++) begin
      sum[i]   = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    cout = c[4];
  end

endmodule

// File: rtl/rca_multiword_seq.sv
// Multi-cycle wide adder: streams SLICE_W-bit slices, LSB first, through one
// shared 4-bit ripple-carry adder with the carry registered between slices.
module rca_multiword_seq #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SLICE_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  import rca_pkg::*;

  localparam int unsigned NSLICE = nslice(WIDTH);
  localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NSLICE - 1);

  if (WIDTH == 0 || (WIDTH % SLICE_W) != 0) begin : g_width_chk
    $fatal(1, "rca_multiword_seq: WIDTH must be a positive multiple of SLICE_W");
  end

  if (SLICE_W != rca_pkg::SLICE_W) begin : g_slice_chk
    $fatal(1, "rca_multiword_seq: SLICE_W must match the 4-bit adder datapath");
  end

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic               carry_reg;
  logic [CNT_W-1:0]   idx;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] s_sl;
  logic               c_sl;

  rca_multiword_seq_rca4 u_adder (
    .a    (a_sl),
    .b    (b_sl),
    .cin  (carry_reg),
    .sum  (s_sl),
    .cout (c_sl)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; busy/done decode straight from the state register.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (abort) begin
          state_nxt = IDLE;
        end else if (idx == LAST) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand slice mux selected by the current slice index.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned i = 0; i < NSLICE; i++) begin
      if (idx == CNT_W'(i)) begin
        a_sl = a_reg[i*SLICE_W +: SLICE_W];
        b_sl = b_reg[i*SLICE_W +: SLICE_W];
      end
    end
  end

  // Operand capture, per-slice sum writeback, carry chaining and abort clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a;
            b_reg     <= b;
            carry_reg <= cin;
            idx       <= '0;
            sum       <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            carry_reg <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
          end else begin
            for (int unsigned i = 0; i < NSLICE; i++) begin
              if (idx == CNT_W'(i)) begin
                sum[i*SLICE_W +: SLICE_W] <= s_sl;
              end
            end
            carry_reg <= c_sl;
            if (idx == LAST) begin
              cout <= c_sl;
              idx  <= '0;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rca_multiword_seq.sv
// Self-checking bench for rca_multiword_seq (WIDTH=16) against a plain
// arithmetic reference: {cout,sum} = a + b + cin.
module tb_rca_multiword_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;

  int errors = 0;
  int checks = 0;

  rca_multiword_seq #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation: issue start, follow it to done, compare with the model.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tc,
                        input bit repulse, input bit with_abort);
    longint unsigned e;
    int cyc;
    int bcnt;
    int extra;
    e = longint'(ta) + longint'(tb) + longint'(tc);
    @(negedge clk);
    a = ta; b = tb; cin = tc; start = 1'b1; abort = with_abort;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    cyc = 1;
    bcnt = 0;
    while (!done && cyc < 20) begin
      if (busy) bcnt++;
      if (repulse && cyc == 2) begin
        start = 1'b1; a = ~ta; b = ~tb; cin = ~tc;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk("latency", 32'(cyc), 32'd5);
    chk("busy_cycles", 32'(bcnt), 32'd4);
    chk("busy_at_done", 32'(busy), 32'd0);
    chk("sum", 32'(sum), 32'(e[15:0]));
    chk("cout", 32'(cout), 32'(e[16]));
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("single_done", 32'(extra), 32'd0);
  endtask

  initial begin
    logic [15:0] ra;
    logic [15:0] rb;
    int extra;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    run_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 1'b0);

    // Abort in slice 2 after a result with cout=1.
    @(negedge clk);
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) extra++;
    end
    chk("abort_no_done", 32'(extra), 32'd0);
    run_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);

    // Result hold over idle cycles.
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_sum", 32'(sum), 32'h5555);
    end

    // Re-pulsed start during RUN is ignored.
    run_op(16'h3C3C, 16'h1F0F, 1'b1, 1'b1, 1'b0);
    // Abort together with start in IDLE: start wins.
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);

    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    for (int n = 0; n < 12; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_op(ra, rb, 1'($urandom), 1'b0, 1'b0);
    end
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-cycle during slice 1.
    @(negedge clk);
    a = 16'h7777; b = 16'h1111; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rca_multiword_seq.md
Name: rca_multiword_seq

Overview:
Multi-cycle controller that adds two WIDTH-bit operands by streaming 4-bit slices through a single shared 4-bit ripple-carry adder, least-significant slice first. The carry is registered between slices.
- Sits between a command source (start pulse plus operands) and any consumer of a wide sum.
- Trades latency for area versus a full-width combinational adder.

Parameters:
WIDTH, 16, operand/sum width in bits; must be a positive multiple of SLICE_W (checked at elaboration, fatal otherwise)
SLICE_W, 4, slice width; fixed to the 4-bit adder datapath

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE
abort  input  1  synchronous cancel of an operation in progress
a  input  WIDTH  operand A; captured on accepted start
b  input  WIDTH  operand B; captured on accepted start
cin  input  1  carry-in; captured on accepted start
busy  output  1  high in RUN
done  output  1  one-cycle pulse; sum/cout valid
sum  output  WIDTH  result register
cout  output  1  final carry-out

Behaviour:
- Reset (rst_n low, asynchronous, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, slice index=0, carry reg=0, operand regs=0.
- NSLICE = WIDTH/SLICE_W. Slice counter is $clog2(NSLICE) bits, minimum 1.
- IDLE: done=0.
  - start=1 at edge k: latch a, b, cin; clear slice index and the sum register; go to RUN.
  - busy=1 from k+1.
- RUN, slice i (cycle i after acceptance, i=0..NSLICE-1):
  - Adder inputs are a_reg[i*4+:4], b_reg[i*4+:4] and carry_reg (carry_reg=cin_reg for i=0).
  - At the edge: sum[i*4+:4] <= adder sum; carry_reg <= adder cout; index increments.
  - After slice NSLICE-1: cout <= adder cout; go to DONE.
- DONE: done=1, busy=0 for exactly one cycle, then IDLE.
- Latency: accepted start at edge k -> done high in the cycle after edge k+NSLICE (NSLICE+1 cycles; 5 for WIDTH=16).
- Output stability: sum/cout hold their value from DONE until the next accepted start. Partially written sum bits may be observed during RUN and are not valid until done.
- start in RUN or DONE: ignored, not queued.
- start in the same cycle as done: ignored; a new start is accepted in the following IDLE cycle.
- abort:
  - In RUN: return to IDLE next edge; no done pulse; sum=0, cout=0.
  - In IDLE or DONE: no effect.
  - abort and start together in IDLE: start wins (abort only affects RUN).
- Arithmetic: unsigned modulo 2^WIDTH; cout is the true carry out of bit WIDTH-1.
- No combinational path from inputs to outputs; all outputs are registered.

Decomposition:
- Shared package rca_pkg:
  - state enum {IDLE, RUN, DONE} (2 bits)
  - SLICE_W=4 constant
  - function nslice(width)
- Sub-module: the team's existing 4-bit ripple-carry adder (ports a, b, cin, sum, cout), instantiated once as the shared slice datapath. The controller holds the FSM, operand/carry registers and slice mux.

Test Plan:
- WIDTH=16: start with a=0x0001, b=0x0002, cin=0 -> done exactly 5 cycles after the start edge; sum=0x0003, cout=0; busy high for 4 cycles.
- a=0xFFFF, b=0x0001, cin=0 -> carry ripples through all 4 slices; sum=0x0000, cout=1.
- a=0xA5A5, b=0x5A5A, cin=1 -> sum=0x0000, cout=1. Then a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, with sum held at 0x5555 for 10 idle cycles afterwards.
- start re-pulsed during RUN with different operands -> ignored; original result delivered; exactly one done pulse.
- abort asserted in slice 2 -> no done pulse; sum=0, cout=0, busy=0 next cycle. A following start with a=0x00FF, b=0x0001 -> sum=0x0100, cout=0.
- rst_n driven low asynchronously (mid-cycle) during slice 1 -> outputs 0 immediately with no clock edge needed; after release, start with a=0x8000, b=0x8000 -> sum=0x0000, cout=1.
